// File: rtl/muxn_pipe_pkg.sv
// Shared definitions for the muxn_pipe selector block.
// Holds the mode encodings and the default channel geometry used by the
// processor datapath (3 channels of 16 bits).
package muxn_pipe_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_NUM_IN = 3;
  localparam int DEFAULT_SEL_W  = 2;

  localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/muxn_pipe_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Starting just after ptr and wrapping at NUM_IN-1 back to 0, reports the
// first requesting channel. ptr itself is scanned last, so the channel that
// won most recently has the lowest priority.
module rr_pick
  import muxn_pipe_pkg::*;
#(
  parameter int NUM_IN = DEFAULT_NUM_IN,
  parameter int SEL_W  = DEFAULT_SEL_W
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  logic [SEL_W-1:0] cand_idx;

  // Scan farthest-first so the nearest requester after ptr overwrites the rest.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      cand_idx = SEL_W'((int'(ptr) + k) % NUM_IN);
      if (req[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// muxn_pipe: N-input WIDTH-bit selector with a registered output stage and
// valid/ready handshakes on every channel. mode=0 selects channel s, mode=1
// round-robins among valid channels.
// Optional feature: define MUXN_PIPE_BEATCNT_EN to add a 16-bit beat_cnt
// output counting accepted output beats.
module muxn_pipe
  import muxn_pipe_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = DEFAULT_NUM_IN,
  parameter int SEL_W  = DEFAULT_SEL_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        s,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUXN_PIPE_BEATCNT_EN
  ,
  output logic [BEAT_CNT_W-1:0]   beat_cnt
`endif
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             take;
  logic             gnt_any;
  logic [SEL_W-1:0] gnt_idx;
  logic             rr_any;
  logic [SEL_W-1:0] rr_idx;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // The output register may accept a new beat when empty or being drained.
  assign load_en = !out_valid_q || out_ready;

  // Pick the granted channel for the current mode; out-of-range s grants nothing.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (mode == MODE_RR) begin
      gnt_any = rr_any;
      gnt_idx = rr_idx;
    end else if (int'(s) < NUM_IN) begin
      gnt_any = in_valid[s];
      gnt_idx = s;
    end
  end

  assign take = gnt_any && load_en;

  // Ready goes only to the granted channel, and only when the register can load.
  always_comb begin
    in_ready = '0;
    if (take) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Next-state for the output register and round-robin pointer: load, drain or hold.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (take) begin
      out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_sel_d   = gnt_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        rr_ptr_d = gnt_idx;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and pointer; pointer resets to the last channel so channel 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SEL_W'(NUM_IN - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

`ifdef MUXN_PIPE_BEATCNT_EN
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Count accepted output beats, wrapping naturally at the counter width.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (out_valid_q && out_ready) begin
      beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
    end
  end

  // Beat counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule
